// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
// ID-stage controller for branch/jump resolution in a 5-stage MIPS pipeline.
// Stalls PC and IF/ID while a branch or jr operand is still being produced
// in EX or MEM. Selects the PC source once the branch or jump resolves and
// flushes the wrong-path fetch. Keeps saturating statistics counters.
//
// Ports
//   Clk, Reset_n          clock (rising edge) and async active-low reset
//   IdValid, Branch       ID holds a valid instruction / conditional branch
//   PCSelect[1:0]         00 PC+4, 01 branch, 10 j/jal, 11 jr
//   UsesRs, UsesRt, Rs, Rt  operand usage and register numbers in ID
//   BranchTaken           compare result on forwarded operands
//   ExRegWrite, ExMemRead, ExRd   EX-stage writer info
//   MemMemRead, MemRd     MEM-stage load info
//   ClearStats            synchronous clear of the statistics counters
//   PCWrite, IfIdWrite, IfIdFlush, IdExBubble, PCSrc, Stalling
//                         combinational pipeline controls
//   BranchCount, TakenCount, StallCycles   registered statistics counters
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOAD_STALL = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             IdValid,
  input  logic             Branch,
  input  logic [1:0]       PCSelect,
  input  logic             UsesRs,
  input  logic             UsesRt,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic             BranchTaken,
  input  logic             ExRegWrite,
  input  logic             ExMemRead,
  input  logic [4:0]       ExRd,
  input  logic             MemMemRead,
  input  logic [4:0]       MemRd,
  input  logic             ClearStats,
  output logic             PCWrite,
  output logic             IfIdWrite,
  output logic             IfIdFlush,
  output logic             IdExBubble,
  output logic [1:0]       PCSrc,
  output logic             Stalling,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] LOAD_W     = 2'(LOAD_STALL);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t     state;
  logic [1:0] cnt;

  logic       ctl;
  logic       ex_need;
  logic       mem_need;
  logic       ex_haz;
  logic       mem_haz;
  logic [1:0] ex_w;
  logic [1:0] mem_w;
  logic [1:0] wait_len;
  logic       resolve;
  logic       redirect;

  // Hazard detection and wait-length selection
  always_comb begin
    ctl      = IdValid & (Branch | (PCSelect != SEL_PC4));
    ex_need  = (ExRd != 5'd0) &
               ((UsesRs & (Rs == ExRd)) | (UsesRt & (Rt == ExRd)));
    mem_need = (MemRd != 5'd0) &
               ((UsesRs & (Rs == MemRd)) | (UsesRt & (Rt == MemRd)));
    // j/jal target comes from the instruction word, never from a register
    ex_haz   = ExRegWrite & ex_need  & (PCSelect != SEL_JUMP);
    mem_haz  = MemMemRead & mem_need & (PCSelect != SEL_JUMP);
    ex_w     = ex_haz  ? (ExMemRead ? LOAD_W : 2'd1) : 2'd0;
    mem_w    = mem_haz ? 2'd1 : 2'd0;
    wait_len = (ex_w > mem_w) ? ex_w : mem_w;
    resolve  = (state == S_RUN) & ctl & (wait_len == 2'd0);
    redirect = resolve & (PCSelect[1] |
               ((PCSelect == SEL_BRANCH) & Branch & BranchTaken));
  end

  // Mealy pipeline controls
  always_comb begin
    PCWrite    = 1'b1;
    IfIdWrite  = 1'b1;
    IfIdFlush  = 1'b0;
    IdExBubble = 1'b0;
    PCSrc      = SEL_PC4;
    Stalling   = 1'b0;
    if ((state == S_WAIT) || (ctl && (wait_len != 2'd0))) begin
      PCWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExBubble = 1'b1;
      Stalling   = 1'b1;
    end else if (redirect) begin
      PCSrc     = PCSelect;
      IfIdFlush = 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // State, wait counter and statistics
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_RUN;
      cnt         <= 2'd0;
      BranchCount <= '0;
      TakenCount  <= '0;
      StallCycles <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (ctl && (wait_len != 2'd0)) begin
            cnt   <= wait_len - 2'd1;
            state <= (wait_len > 2'd1) ? S_WAIT : S_RUN;
          end
        end
        S_WAIT: begin
          // IdValid is not consulted: an accepted stall always completes
          cnt <= cnt - 2'd1;
          if (cnt <= 2'd1) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase

      if (ClearStats) begin
        BranchCount <= '0;
        TakenCount  <= '0;
        StallCycles <= '0;
      end else begin
        if (resolve && Branch) BranchCount <= sat_inc(BranchCount);
        if (redirect)          TakenCount  <= sat_inc(TakenCount);
        if (Stalling)          StallCycles <= sat_inc(StallCycles);
      end
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed testbench for branch_hazard_ctrl.
module tb_branch_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             Clk;
  logic             Reset_n;
  logic             IdValid, Branch, UsesRs, UsesRt, BranchTaken;
  logic [1:0]       PCSelect;
  logic [4:0]       Rs, Rt, ExRd, MemRd;
  logic             ExRegWrite, ExMemRead, MemMemRead, ClearStats;
  logic             PCWrite, IfIdWrite, IfIdFlush, IdExBubble, Stalling;
  logic [1:0]       PCSrc;
  logic [CNT_W-1:0] BranchCount, TakenCount, StallCycles;

  int n_checks = 0;
  int n_errors = 0;

  branch_hazard_ctrl #(.CNT_W(CNT_W), .LOAD_STALL(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .IdValid(IdValid), .Branch(Branch),
    .PCSelect(PCSelect), .UsesRs(UsesRs), .UsesRt(UsesRt), .Rs(Rs), .Rt(Rt),
    .BranchTaken(BranchTaken), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExRd(ExRd), .MemMemRead(MemMemRead), .MemRd(MemRd),
    .ClearStats(ClearStats), .PCWrite(PCWrite), .IfIdWrite(IfIdWrite),
    .IfIdFlush(IfIdFlush), .IdExBubble(IdExBubble), .PCSrc(PCSrc),
    .Stalling(Stalling), .BranchCount(BranchCount), .TakenCount(TakenCount),
    .StallCycles(StallCycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    IdValid = 0; Branch = 0; PCSelect = 2'b00; UsesRs = 0; UsesRt = 0;
    Rs = 0; Rt = 0; BranchTaken = 0; ExRegWrite = 0; ExMemRead = 0;
    ExRd = 0; MemMemRead = 0; MemRd = 0; ClearStats = 0;
  endtask

  task automatic check_stall(input string tag);
    check({tag, "_pcwrite"}, 32'(PCWrite), 32'd0);
    check({tag, "_ifidwrite"}, 32'(IfIdWrite), 32'd0);
    check({tag, "_bubble"}, 32'(IdExBubble), 32'd1);
    check({tag, "_stalling"}, 32'(Stalling), 32'd1);
    check({tag, "_pcsrc"}, 32'(PCSrc), 32'd0);
    check({tag, "_flush"}, 32'(IfIdFlush), 32'd0);
  endtask

  task automatic check_resolve(input string tag, input logic [1:0] src,
                               input logic flush);
    check({tag, "_pcwrite"}, 32'(PCWrite), 32'd1);
    check({tag, "_ifidwrite"}, 32'(IfIdWrite), 32'd1);
    check({tag, "_bubble"}, 32'(IdExBubble), 32'd0);
    check({tag, "_stalling"}, 32'(Stalling), 32'd0);
    check({tag, "_pcsrc"}, 32'(PCSrc), 32'(src));
    check({tag, "_flush"}, 32'(IfIdFlush), 32'(flush));
  endtask

  task automatic check_counts(input string tag, input int b, input int t,
                              input int s);
    check({tag, "_branchcount"}, 32'(BranchCount), 32'(b));
    check({tag, "_takencount"}, 32'(TakenCount), 32'(t));
    check({tag, "_stallcycles"}, 32'(StallCycles), 32'(s));
  endtask

  initial begin
    clear_inputs();
    Reset_n = 0;
    #12;
    check_resolve("reset_idle", 2'b00, 1'b0);
    check_counts("reset", 0, 0, 0);
    Reset_n = 1;
    step();

    // beq $t1,$t2 taken, no hazard
    IdValid = 1; Branch = 1; PCSelect = 2'b01; UsesRs = 1; UsesRt = 1;
    Rs = 9; Rt = 10; BranchTaken = 1;
    #1 check_resolve("beq_taken", 2'b01, 1'b1);
    step();
    check_counts("beq_taken", 1, 1, 0);

    // bgez $t1 behind a load writing $t1: two stalls
    UsesRt = 0; Rt = 1; ExRegWrite = 1; ExMemRead = 1; ExRd = 9;
    #1 check_stall("bgez_stall1");
    step();
    ExRegWrite = 0; ExMemRead = 0; ExRd = 0; MemMemRead = 1; MemRd = 9;
    #1 check_stall("bgez_stall2");
    step();
    MemMemRead = 0; MemRd = 0; BranchTaken = 0;
    #1 check_resolve("bgez_resolve", 2'b00, 1'b0);
    step();
    check_counts("bgez", 2, 1, 2);

    // bne: EX ALU op on $t2 and MEM load on $t1 -> single stall
    UsesRt = 1; Rt = 10; ExRegWrite = 1; ExRd = 10; MemMemRead = 1; MemRd = 9;
    #1 check_stall("bne_stall");
    step();
    ExRegWrite = 0; ExRd = 0; MemMemRead = 0; MemRd = 0; BranchTaken = 1;
    #1 check_resolve("bne_resolve", 2'b01, 1'b1);
    step();
    check_counts("bne", 3, 2, 3);

    // bne with writer to $zero: no stall
    ExRegWrite = 1; ExRd = 0; BranchTaken = 0;
    #1 check_resolve("bne_r0", 2'b00, 1'b0);
    step();
    check_counts("bne_r0", 4, 2, 3);

    // j behind a load to Rs: no stall
    Branch = 0; PCSelect = 2'b10; UsesRs = 1; UsesRt = 0; Rs = 9;
    ExRegWrite = 1; ExMemRead = 1; ExRd = 9;
    #1 check_resolve("j_nostall", 2'b10, 1'b1);
    step();
    check_counts("j", 4, 3, 3);

    // jr $t1 in the same setup: two stalls then redirect
    PCSelect = 2'b11;
    #1 check_stall("jr_stall1");
    step();
    ExRegWrite = 0; ExMemRead = 0; ExRd = 0; MemMemRead = 1; MemRd = 9;
    #1 check_stall("jr_stall2");
    step();
    MemMemRead = 0; MemRd = 0;
    #1 check_resolve("jr_resolve", 2'b11, 1'b1);
    step();
    check_counts("jr", 4, 4, 5);

    // Enter WAIT, drop IdValid (stall holds), then reset mid-WAIT
    ExRegWrite = 1; ExMemRead = 1; ExRd = 9;
    #1 check_stall("wait_entry");
    step();
    IdValid = 0; ExRegWrite = 0; ExMemRead = 0; ExRd = 0;
    #1 check_stall("wait_idvalid_low");
    #2 Reset_n = 0;
    #1 check_resolve("reset_midwait", 2'b00, 1'b0);
    check_counts("reset_midwait", 0, 0, 0);
    Reset_n = 1;
    clear_inputs();
    step();
    check_resolve("after_reset", 2'b00, 1'b0);

    // ClearStats overrides an increment in the same cycle
    IdValid = 1; Branch = 1; PCSelect = 2'b01; UsesRs = 1; UsesRt = 1;
    Rs = 9; Rt = 10; BranchTaken = 1;
    step();
    check_counts("pre_clear", 1, 1, 0);
    ClearStats = 1;
    #1 check_resolve("clear_branch", 2'b01, 1'b1);
    step();
    check_counts("clear_same_cycle", 0, 0, 0);
    ClearStats = 0;

    // Saturation: drive TakenCount to 0xFFFE with jumps, then two more
    Branch = 0; PCSelect = 2'b10;
    for (int i = 0; i < 65534; i++) step();
    check("taken_fffe", 32'(TakenCount), 32'h0000_FFFE);
    step();
    check("taken_ffff", 32'(TakenCount), 32'h0000_FFFF);
    step();
    check("taken_saturated", 32'(TakenCount), 32'h0000_FFFF);
    check("branch_unchanged", 32'(BranchCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- ID-stage controller that sequences the branch/jump resolution datapath of the 5-stage MIPS pipeline.
- Detects operand hazards for branch/jr in ID and stalls PC/IF-ID for the required cycles.
- Selects the PC source when the branch/jump resolves and flushes the wrong-path fetch.
- Keeps saturating statistics counters for branches, taken redirects and stall cycles.

Parameters:
CNT_W, 16, width of the statistics counters.
LOAD_STALL, 2, stall cycles when a load in EX produces a needed register (must be 1..3).

Ports:
Clk  input  1  clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
IdValid  input  1  ID holds a valid instruction.
Branch  input  1  decoded conditional branch (beq/bne/bgez/bgtz/blez/bltz).
PCSelect  input  2  decoded PC source: 00 PC+4, 01 branch target, 10 j/jal target, 11 jr register.
UsesRs  input  1  ID instruction reads rs in branch compare or jr.
UsesRt  input  1  ID instruction reads rt in branch compare.
Rs  input  5  rs number.
Rt  input  5  rt number.
BranchTaken  input  1  branch-unit compare result on forwarded operands; valid only when no hazard is flagged.
ExRegWrite  input  1  EX instruction writes a register.
ExMemRead  input  1  EX instruction is a load.
ExRd  input  5  EX destination register.
MemMemRead  input  1  MEM instruction is a load.
MemRd  input  5  MEM destination register.
ClearStats  input  1  synchronous clear of the statistics counters.
PCWrite  output  1  PC register enable.
IfIdWrite  output  1  IF/ID enable.
IfIdFlush  output  1  zero IF/ID on the next edge.
IdExBubble  output  1  insert a nop into ID/EX.
PCSrc  output  2  PC mux select, same encoding as PCSelect.
Stalling  output  1  high while in WAIT or entering WAIT.
BranchCount  output  CNT_W  resolved conditional branches.
TakenCount  output  CNT_W  taken redirects, including jumps.
StallCycles  output  CNT_W  cycles with Stalling=1.

Behaviour:
- States: RUN and WAIT. A down-counter Cnt (2 bits) is active in WAIT.
- Reset (asynchronous, any state): state RUN, Cnt=0, all counters 0.
- Reset values of the combinational outputs at idle: PCWrite=1, IfIdWrite=1, IfIdFlush=0, IdExBubble=0, PCSrc=00, Stalling=0.
- All control outputs are combinational (Mealy) from state and inputs. Counters are registered.
- ctl = IdValid & (Branch | PCSelect != 00).
- need(r) = (UsesRs & Rs == r) | (UsesRt & Rt == r), with r != 0.
- Register 0 never creates a hazard.
- ExHaz = ExRegWrite & need(ExRd). Wait length = LOAD_STALL if ExMemRead, else 1.
- MemHaz = MemMemRead & need(MemRd). Wait length = 1.
- PCSelect 10 (j/jal) never hazards; it ignores UsesRs/UsesRt.
- W = maximum wait length over the asserted hazards. If both ExHaz and MemHaz hold, the larger value is used.
- RUN, ctl and W > 0:
  - PCWrite=0, IfIdWrite=0, IdExBubble=1, PCSrc=00, Stalling=1.
  - Next state: Cnt=W-1. Go to WAIT if W > 1, otherwise stay in RUN.
  - No redirect this cycle; BranchTaken is ignored.
- WAIT: same outputs as a stalling RUN cycle. Cnt decrements each cycle. When Cnt reaches 0 (last WAIT cycle), next state is RUN.
- A stall always ends in RUN, where hazards are re-evaluated. A residual hazard stalls again.
- RUN, ctl and W == 0 (resolve cycle):
  - Redirect when PCSelect is 10 or 11, or when PCSelect == 01 & Branch & BranchTaken.
  - On redirect: PCSrc=PCSelect, IfIdFlush=1, PCWrite=1, IfIdWrite=1.
  - On no redirect: PCSrc=00, no flush.
  - BranchCount+1 if Branch. TakenCount+1 on redirect.
- RUN, ctl=0: idle outputs.
- StallCycles+1 on every cycle with Stalling=1.
- All counters saturate at all-ones.
- ClearStats zeroes the counters on the next edge and overrides any increment in the same cycle. It does not affect the FSM.
- IdValid dropping during WAIT does not abort the stall; WAIT completes.

Test Plan:
- Reset_n=0 asserted mid-WAIT (Cnt=1) -> immediately state RUN, PCWrite=1, all counters 0.
- beq $t1,$t2 (Rs=9, Rt=10), no EX/MEM hazard, BranchTaken=1 -> same cycle PCSrc=01, IfIdFlush=1; BranchCount=1, TakenCount=1.
- bgez $t1 with EX load writing ExRd=9 -> 2 stall cycles (PCWrite=0, IdExBubble=1); third cycle resolves; StallCycles=2.
- bne with EX ALU op ExRd=10 and MEM load MemRd=9 -> exactly 1 stall cycle, then resolve. With ExRd=0 instead -> 0 stall cycles.
- j 4 (PCSelect=10) with ExRd=Rs=9, ExMemRead=1 -> no stall, PCSrc=10, IfIdFlush=1. jr $t1 in the same setup -> 2 stalls, then PCSrc=11.
- Counters preloaded near saturation (0xFFFE) plus two taken branches -> TakenCount stays 0xFFFF. ClearStats asserted in the same cycle as a taken branch -> TakenCount=0 after the edge.
